// File: rtl/beta_mem_stage.sv
// beta_mem_stage: Beta MEM pipeline register with req/ack data memory, stall and timeout trap
module beta_mem_stage #(
   parameter int DW = 32,
   parameter logic [DW-1:0] NOP_IR = 32'h83FF_FFFF,
   parameter logic [DW-1:0] TRAP_IR = 32'h7BDF_FFFF,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    irsrc,
   input  logic [DW-1:0] pc_in,
   input  logic [DW-1:0] ir_in,
   input  logic [DW-1:0] y_in,
   input  logic [DW-1:0] d_in,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_req,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_oe,
   output logic          stall_out,
   output logic          mem_fault,
   output logic [DW-1:0] pc_out,
   output logic [DW-1:0] ir_out,
   output logic [DW-1:0] y_out,
   output logic [DW-1:0] mdata_out
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [5:0] OP_LD = 6'b011000, OP_LDR = 6'b011111, OP_ST = 6'b011001;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state;
   logic [DW-1:0] pc, ir, y, d, mdata, nxt_ir;
   logic [CW-1:0] wait_cnt;
   logic [5:0] op, nxt_op;
   logic ld, st, nxt_mem, timeout_hit, load_en;
   assign op = ir[DW-1:DW-6];
   assign ld = op == OP_LD || op == OP_LDR;
   assign st = op == OP_ST;
   assign timeout_hit = TIMEOUT != 0 && state == WAIT && !mem_ack && wait_cnt == CW'(TIMEOUT - 1);
   assign stall_out = state == WAIT && !mem_ack && !timeout_hit;
   assign load_en = !stall_out;
   assign nxt_ir = timeout_hit ? TRAP_IR : irsrc == 2'd0 ? ir_in : irsrc == 2'd1 ? TRAP_IR : NOP_IR;
   assign nxt_op = nxt_ir[DW-1:DW-6];
   assign nxt_mem = nxt_op == OP_LD || nxt_op == OP_LDR || nxt_op == OP_ST;
   assign mem_req = state == WAIT;
   assign mem_we = mem_req && st;
   assign mem_oe = mem_req && ld;
   assign mem_addr = y;
   assign mem_wdata = d;
   assign pc_out = pc;
   assign ir_out = ir;
   assign y_out = y;
   assign mdata_out = mdata;
   // pipeline registers advance unless an access is outstanding; a timeout releases the stall and forces a trap
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ir <= NOP_IR;
         pc <= '0;
         y <= '0;
         d <= '0;
         mdata <= '0;
         wait_cnt <= '0;
         mem_fault <= 1'b0;
      end else begin
         mem_fault <= timeout_hit;
         if (state == WAIT && mem_ack && ld) mdata <= mem_rdata;
         if (load_en) begin
            pc <= pc_in;
            y <= y_in;
            d <= d_in;
            ir <= nxt_ir;
            state <= nxt_mem ? WAIT : IDLE;
            wait_cnt <= '0;
         end else wait_cnt <= wait_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_beta_mem_stage.sv
// tb_beta_mem_stage: randomized check of beta_mem_stage against a cycle-level behavioural model
module tb_beta_mem_stage;
   localparam int TO = 4;
   localparam logic [31:0] NOP = 32'h83FF_FFFF, TRAP = 32'h7BDF_FFFF;
   localparam logic [31:0] LD = 32'h6000_0000, LDR = 32'h7C00_0000, ST = 32'h6400_0000, ADD = 32'h8000_0000;
   logic clk = 0, reset = 0, mem_ack = 0;
   logic [1:0] irsrc = 0;
   logic [31:0] pc_in = 0, ir_in = 0, y_in = 0, d_in = 0, mem_rdata = 0;
   logic mem_req, mem_we, mem_oe, stall_out, mem_fault;
   logic [31:0] mem_addr, mem_wdata, pc_out, ir_out, y_out, mdata_out;
   int n_chk = 0, n_pass = 0;
   logic armed = 0;
   logic [31:0] m_pc, m_ir, m_y, m_d, m_md;
   logic m_fault;
   int m_age;

   beta_mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .irsrc(irsrc), .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .d_in(d_in),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe), .stall_out(stall_out),
      .mem_fault(mem_fault), .pc_out(pc_out), .ir_out(ir_out), .y_out(y_out), .mdata_out(mdata_out)
   );

   always #5 clk = ~clk;

   function automatic logic is_ld(input logic [31:0] x);
      return x[31:26] == 6'b011000 || x[31:26] == 6'b011111;
   endfunction

   function automatic logic is_st(input logic [31:0] x);
      return x[31:26] == 6'b011001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
   endtask

   task automatic cyc(input logic r, input logic [1:0] s, input logic [31:0] i, p, yy, dd,
                      input logic a, input logic [31:0] rd);
      logic busy, tmo, stl;
      @(negedge clk);
      reset = r; irsrc = s; ir_in = i; pc_in = p; y_in = yy; d_in = dd; mem_ack = a; mem_rdata = rd;
      #1;
      busy = m_age >= 0;
      tmo = busy && !a && m_age == TO - 1;
      stl = busy && !a && !tmo;
      if (armed) begin
         chk("req", mem_req, busy);
         chk("we", mem_we, busy && is_st(m_ir));
         chk("oe", mem_oe, busy && is_ld(m_ir));
         chk("stall", stall_out, stl);
         chk("fault", mem_fault, m_fault);
         chk("addr", mem_addr, m_y);
         chk("wdata", mem_wdata, m_d);
         chk("pc", pc_out, m_pc);
         chk("ir", ir_out, m_ir);
         chk("y", y_out, m_y);
         chk("mdata", mdata_out, m_md);
      end
      @(posedge clk);
      if (r) begin
         armed = 1;
         m_pc = 0; m_ir = NOP; m_y = 0; m_d = 0; m_md = 0; m_fault = 0; m_age = -1;
      end else begin
         m_fault = tmo;
         if (busy && a && is_ld(m_ir)) m_md = rd;
         if (stl) m_age++;
         else begin
            m_ir = tmo ? TRAP : s == 0 ? i : s == 1 ? TRAP : NOP;
            m_pc = p; m_y = yy; m_d = dd;
            m_age = (is_ld(m_ir) || is_st(m_ir)) ? 0 : -1;
         end
      end
   endtask

   function automatic logic [31:0] rnd_ir();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 3))
         0: return LD | (x & 32'h03FF_FFFF);
         1: return LDR | (x & 32'h03FF_FFFF);
         2: return ST | (x & 32'h03FF_FFFF);
         default: return x;
      endcase
   endfunction

   initial begin
      m_age = -1; m_ir = NOP; m_pc = 0; m_y = 0; m_d = 0; m_md = 0; m_fault = 0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, ADD, 32'h10, 32'h5, 32'h6, 0, 0);
      cyc(0, 0, LD, 32'h14, 32'h100, 32'h7, 1, 32'h1111);
      cyc(0, 0, ST, 32'h18, 32'h200, 32'hCAFE, 1, 32'hDEADBEEF);
      cyc(0, 0, ADD, 32'h1C, 32'h9, 32'h9, 1, 32'h2222);
      cyc(0, 0, ADD, 32'h20, 32'h9, 32'h9, 1, 32'h3333);
      cyc(0, 0, LD, 32'h24, 32'h300, 0, 0, 0);
      cyc(0, 0, ADD, 32'h28, 1, 1, 0, 0);
      cyc(0, 2, ADD, 32'h2C, 2, 2, 0, 0);
      cyc(0, 0, ADD, 32'h30, 3, 3, 0, 0);
      cyc(0, 0, ADD, 32'h34, 4, 4, 1, 32'h5555_AAAA);
      cyc(0, 1, LD, 32'h38, 5, 5, 0, 0);
      cyc(0, 3, LD, 32'h3C, 6, 6, 0, 0);
      cyc(0, 0, ST, 32'h40, 7, 32'hBEEF, 0, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, ADD, 32'h44 + k, k, k, 0, 0);
      cyc(0, 0, LD, 32'h60, 8, 8, 0, 0);
      cyc(0, 0, ADD, 32'h64, 9, 9, 0, 0);
      cyc(1, 0, ADD, 32'h68, 9, 9, 0, 0);
      cyc(0, 0, ADD, 32'h6C, 9, 9, 0, 0);
      for (int k = 0; k < 1500; k++) begin
         int ack_pct;
         ack_pct = k < 300 ? 100 : k < 900 ? 50 : 12;
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 5) < 4 ? 2'd0 : 2'($urandom_range(1, 3)),
             rnd_ir(), $urandom, $urandom, $urandom, $urandom_range(0, 99) < ack_pct, $urandom);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
